instr_fetch: RTL and testbench

Instruction fetch stage of the MiniMIPS core, directly upstream of the main control decoder. Holds the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, presents the held instruction and its 4-bit opcode to decode with a valid/ready handshake, and redirects the PC on taken `beq`/`bne`. Sequential next-PC by default; stops fetching after a halt opcode.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// MiniMIPS instruction fetch stage: PC, req/ack fetch from imem, valid/ready hand-off to decode.
// Optional IFETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module instr_fetch #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            branch,
    input  logic            branchne,
    input  logic            alu_zero,
`ifdef IFETCH_PERF_CNT_EN
    output logic [15:0]     fetch_cnt,
    output logic [15:0]     stall_cnt,
`endif
    output logic            halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [3:0] OP_HALT = 4'b1111;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            taken;
    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] next_pc;

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
`endif

    // Branch target: relative to the address after the held instruction, modulo 2^PC_W.
    assign taken    = (branch & alu_zero) | (branchne & ~alu_zero);
    assign imm_sext = {{(PC_W-6){instr_q[5]}}, instr_q[5:0]};
    assign next_pc  = instr_pc_q + PC_W'(1) + (taken ? imm_sext : '0);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = (instr_q[15:12] == OP_HALT) ? HALT : FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

`ifdef IFETCH_PERF_CNT_EN
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == FETCH && imem_ack)
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (state_q == HOLD && !instr_ready)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
`ifdef IFETCH_PERF_CNT_EN
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
`ifdef IFETCH_PERF_CNT_EN
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    // Handshake outputs are pure decodes of registered state, so they are glitch-free.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign halted      = (state_q == HALT);
    assign instr       = instr_q;
    assign opcode      = instr_q[15:12];
    assign instr_pc    = instr_pc_q;
`ifdef IFETCH_PERF_CNT_EN
    assign fetch_cnt   = fetch_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; covers counters when IFETCH_PERF_CNT_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        branchne;
    logic        alu_zero;
    logic        halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch      (branch),
        .branchne    (branchne),
        .alu_zero    (alu_zero),
`ifdef IFETCH_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: assumes the DUT is in FETCH, inserts wait states, then acks.
    task automatic do_fetch(input logic [15:0] data, input int waits);
        repeat (waits) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    // Stimulus only: one consume edge with the given decoder/ALU flags.
    task automatic do_consume(input logic b, input logic bne, input logic z);
        instr_ready = 1'b1;
        branch      = b;
        branchne    = bne;
        alu_zero    = z;
        tick();
        instr_ready = 1'b0;
        branch      = 1'b0;
        branchne    = 1'b0;
        alu_zero    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h/%h want 0000/0000", instr, instr_pc); end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if (fetch_cnt !== 16'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
`endif
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL first_req: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic exp_valid;
        do_fetch(16'h0123, 0);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b want 1", instr_valid); end
        checks++; if (instr !== 16'h0123 || opcode !== 4'h0) begin errors++; $display("FAIL zw_instr: got %h op %h want 0123 op 0", instr, opcode); end
        checks++; if (instr_pc !== 16'h0000 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_pc: got pc=%h req=%b want 0000/0", instr_pc, imem_req); end
        do_consume(1'b0, 1'b0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL zw_next: got req=%b addr=%h want 1/0001", imem_req, imem_addr); end
        // Ready and ack held high: valid alternates 1,0,1,0; ack seen in HOLD is ignored.
        imem_ack    = 1'b1;
        imem_rdata  = 16'h1234;
        instr_ready = 1'b1;
        exp_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL zw_pulse%0d: got %b want %b", i, instr_valid, exp_valid); end
            exp_valid = ~exp_valid;
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        checks++; if (imem_addr !== 16'h0003 || instr_pc !== 16'h0002) begin errors++; $display("FAIL zw_seq: got addr=%h ipc=%h want 0003/0002", imem_addr, instr_pc); end
    endtask

    task automatic test_wait_stall();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin errors++; $display("FAIL wait%0d: got req=%b addr=%h want 1/0003", i, imem_req, imem_addr); end
        end
        do_fetch(16'hA5C3, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr !== 16'hA5C3 || instr_pc !== 16'h0003) begin errors++; $display("FAIL stall%0d: got v=%b instr=%h ipc=%h want 1/a5c3/0003", i, instr_valid, instr, instr_pc); end
        end
`ifdef IFETCH_PERF_CNT_EN
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
        checks++; if (fetch_cnt !== 16'd4) begin errors++; $display("FAIL fetch_cnt: got %0d want 4", fetch_cnt); end
`endif
        do_consume(1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL stall_next: got %h want 0004", imem_addr); end
    endtask

    task automatic test_branch();
        do_fetch(16'h500B, 0);            // bne +11 at 0x0004 -> 0x0010
        do_consume(1'b0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL br_setup: got %h want 0010", imem_addr); end
        do_fetch(16'h403E, 1);            // beq -2, taken
        checks++; if (instr_pc !== 16'h0010) begin errors++; $display("FAIL br_ipc: got %h want 0010", instr_pc); end
        do_consume(1'b1, 1'b0, 1'b1);
        checks++; if (imem_addr !== 16'h000F) begin errors++; $display("FAIL beq_taken: got %h want 000f", imem_addr); end
        do_fetch(16'h1000, 0);
        do_consume(1'b0, 1'b0, 1'b0);
        do_fetch(16'h403E, 0);            // beq -2, not taken
        do_consume(1'b1, 1'b0, 1'b0);
        checks++; if (imem_addr !== 16'h0011) begin errors++; $display("FAIL beq_not_taken: got %h want 0011", imem_addr); end
        do_fetch(16'h503E, 0);            // bne -2 back to 0x0010
        do_consume(1'b0, 1'b1, 1'b0);
        do_fetch(16'h5005, 0);
        do_consume(1'b0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 16'h0016) begin errors++; $display("FAIL bne_taken: got %h want 0016", imem_addr); end
        do_fetch(16'h7003, 0);            // both flags high: always taken
        do_consume(1'b1, 1'b1, 1'b0);
        checks++; if (imem_addr !== 16'h001A) begin errors++; $display("FAIL both_taken: got %h want 001a", imem_addr); end
    endtask

    task automatic test_wrap();
        do_fetch(16'h5025, 0);            // bne -27 at 0x001A -> 0x0000
        do_consume(1'b0, 1'b1, 1'b0);
        do_fetch(16'h503E, 0);            // bne -2 at 0x0000 -> 0xFFFF
        do_consume(1'b0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_neg: got %h want ffff", imem_addr); end
        do_fetch(16'h1000, 0);
        checks++; if (instr_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_ipc: got %h want ffff", instr_pc); end
        do_consume(1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pos: got %h want 0000", imem_addr); end
    endtask

    task automatic test_halt();
        int bad;
        do_fetch(16'hF000, 0);
        checks++; if (opcode !== 4'hF) begin errors++; $display("FAIL halt_op: got %h want f", opcode); end
        do_consume(1'b0, 1'b0, 1'b0);
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: got h=%b v=%b want 1/0", halted, instr_valid); end
        imem_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        imem_ack = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_reset: got h=%b addr=%h want 0/0000", halted, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_restart: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        do_fetch(16'h1000, 0);
        do_consume(1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL rmf_setup: got %h want 0001", imem_addr); end
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmf_state: got v=%b req=%b want 0/0", instr_valid, imem_req); end
        checks++; if (instr !== 16'h0000 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rmf_regs: got instr=%h addr=%h want 0000/0000", instr, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin errors++; $display("FAIL rmf_restart: got req=%b addr=%h v=%b want 1/0000/0", imem_req, imem_addr, instr_valid); end
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        branch      = 1'b0;
        branchne    = 1'b0;
        alu_zero    = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
